dem_unscramble: RTL and testbench
=================================

DEM_UNSCRAMBLE -- requirements
Module: dem_unscramble

Interface
REQ-001 Parameters: none; the permutation table is fixed by REQ-011.
REQ-002 dem_clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 y  in  8  scrambled unit-element word from the dem block; bit pairs (2i, 2i+1) form group i, for i = 0..3.
REQ-005 ybar  in  8  complementary-rail word from the dem block; passed through with no unscrambling.
REQ-006 x_ref  in  8  original unit-element word at the dem input, same cycle the dem block sampled it; used for checking only.
REQ-007 clr  in  1  synchronous clear of the error state.
REQ-008 x_rec  out  8  recovered unit-element word.
REQ-009 xbar_rec  out  8  registered copy of ybar.
REQ-010 ones  out  4  popcount of x_rec, range 0..8; err_pulse  out  1  one-cycle mismatch strobe; err_cnt  out  8  saturating mismatch count; locked  out  1  tracking-state indicator.

Function
REQ-011 Table T[0..31], with digits giving p0 p1 p2 p3:
- 0123 0132 0213 0231 0312 0321 1023 1032
- 1230 1203 1320 1302 2301 2310 2130 2103
- 2013 2031 3021 3012 3102 3120 3201 3210
- 3210 2130 0231 1023 1320 0123 3012 2310
REQ-012 Inverse mapping for group i, using p = T[n_d].p_i: x_rec[7-2p] = y[2i] and x_rec[6-2p] = y[2i+1].
REQ-013 Counter n_d is 5 bits, resets to 0, and wraps 31 -> 0.
REQ-014 n_d increments by 1 on every edge where the state is TRACK.
REQ-015 FSM states are PRIME and TRACK; reset enters PRIME.
REQ-016 PRIME lasts exactly one edge; that edge discards y, which is still at its reset value, and moves to TRACK.
REQ-017 In TRACK, each edge sets x_rec <= inverse(y, n_d), xbar_rec <= ybar, and ones <= popcount(inverse(y, n_d)).
REQ-018 End-to-end latency from x_ref at the dem input to x_rec is 2 dem_clk cycles.
REQ-019 x_ref passes through a 2-stage delay line so that it aligns with x_rec.
REQ-020 The check register is valid from the third edge after reset onward; edges before that shall never flag an error.
REQ-021 A mismatch (x_rec != aligned x_ref while check-valid) shall raise err_pulse for exactly one cycle, registered one edge after x_rec updates.
REQ-022 Each mismatch increments err_cnt, which saturates at 255.
REQ-023 locked is 1 in TRACK while err_cnt == 0.
REQ-024 locked drops to 0 on the first mismatch.
REQ-025 locked stays 0 until clr is asserted.
REQ-026 clr zeroes err_cnt and err_pulse on the next edge; n_d and the datapath are unaffected.
REQ-027 If clr and a mismatch occur on the same edge, clr wins: err_cnt = 0 and err_pulse = 0.
REQ-028 The datapath has no stall input; a change of y every cycle is the normal case.

Reset
REQ-029 Asserting reset_n low at any time, including mid-stream, shall immediately produce: x_rec = 0x00, xbar_rec = 0xFF, ones = 0, err_pulse = 0, err_cnt = 0, locked = 0, n_d = 0, state = PRIME, delay line = 0x00.
REQ-030 After release, the first edge is the PRIME edge.
REQ-031 The bench shall release reset for dem and dem_unscramble in the same cycle; alignment depends on this.

Verification
REQ-032 Reset release, then x_ref = 0xFF constant -> x_rec = 0xFF and ones = 8 from the 2nd post-reset edge onward; err_cnt stays 0; locked = 1.
REQ-033 Walking one on x_ref (0x01, 0x02, ... 0x80) fed through dem for 64 cycles -> x_rec equals x_ref delayed 2 cycles for every n_d 0..31 across two wraps; err_cnt = 0.
REQ-034 Case n_d = 4 (T = 0312) with y = 0x01 -> x_rec = 0x80; with y = 0x04 -> x_rec = 0x02.
REQ-035 Force one corrupted y bit at cycle 10 -> err_pulse high for exactly 1 cycle, err_cnt = 1, locked = 0.
REQ-036 Corrupt y for 300 cycles -> err_cnt saturates at 255; clr asserted together with a mismatch -> err_cnt = 0 and err_pulse = 0 on the next edge.
REQ-037 Reset pulse mid-stream at n_d = 17 -> all outputs return to their reset values; after release, tracking re-aligns with dem and no mismatch is flagged.

Source files
------------

// File: rtl/dem_unscramble_if.sv
// Bundle of the scrambled-word inputs and the recovered/status outputs of
// the DEM unscrambler. The master drives the dem words and the clear; the
// slave (dem_unscramble) returns the recovered word and the lock/error status.
interface dem_unscramble_if;
    logic [7:0] y;
    logic [7:0] ybar;
    logic [7:0] x_ref;
    logic       clr;
    logic [7:0] x_rec;
    logic [7:0] xbar_rec;
    logic [3:0] ones;
    logic       err_pulse;
    logic [7:0] err_cnt;
    logic       locked;

    modport master (
        output y, ybar, x_ref, clr,
        input  x_rec, xbar_rec, ones, err_pulse, err_cnt, locked
    );

    modport slave (
        input  y, ybar, x_ref, clr,
        output x_rec, xbar_rec, ones, err_pulse, err_cnt, locked
    );
endinterface

// File: rtl/dem_unscramble.sv
// DEM unscrambler: undoes the per-cycle group permutation applied by the dem
// block, tracking the dem rotation index with a local counter. A two-stage
// delay of the dem input word is compared with the recovered word to detect
// loss of alignment, reported as a strobe, a saturating count and a lock flag.
module dem_unscramble (
    input  logic            dem_clk,
    input  logic            reset_n,
    dem_unscramble_if.slave bus
);

    typedef enum logic [0:0] {
        ST_PRIME = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic       track_s;
    logic [4:0] n_d_r;
    logic [7:0] x_rec_r;
    logic [7:0] xbar_rec_r;
    logic [3:0] ones_r;
    logic [7:0] x_dly1_r;
    logic [7:0] x_dly2_r;
    logic       chk_valid_r;
    logic       mismatch_s;
    logic [7:0] err_cnt_r;
    logic [7:0] err_cnt_nxt_s;
    logic       err_pulse_r;
    logic       err_pulse_nxt_s;
    logic       locked_r;
    logic       locked_nxt_s;
    logic [7:0] inverse_s;
    logic [3:0] ones_s;

    // Permutation entry for rotation index idx, packed as {p0, p1, p2, p3}.
    function automatic logic [7:0] perm_entry(input logic [4:0] idx);
        logic [7:0] e;
        case (idx)
            5'd0:    e = {2'd0, 2'd1, 2'd2, 2'd3};
            5'd1:    e = {2'd0, 2'd1, 2'd3, 2'd2};
            5'd2:    e = {2'd0, 2'd2, 2'd1, 2'd3};
            5'd3:    e = {2'd0, 2'd2, 2'd3, 2'd1};
            5'd4:    e = {2'd0, 2'd3, 2'd1, 2'd2};
            5'd5:    e = {2'd0, 2'd3, 2'd2, 2'd1};
            5'd6:    e = {2'd1, 2'd0, 2'd2, 2'd3};
            5'd7:    e = {2'd1, 2'd0, 2'd3, 2'd2};
            5'd8:    e = {2'd1, 2'd2, 2'd3, 2'd0};
            5'd9:    e = {2'd1, 2'd2, 2'd0, 2'd3};
            5'd10:   e = {2'd1, 2'd3, 2'd2, 2'd0};
            5'd11:   e = {2'd1, 2'd3, 2'd0, 2'd2};
            5'd12:   e = {2'd2, 2'd3, 2'd0, 2'd1};
            5'd13:   e = {2'd2, 2'd3, 2'd1, 2'd0};
            5'd14:   e = {2'd2, 2'd1, 2'd3, 2'd0};
            5'd15:   e = {2'd2, 2'd1, 2'd0, 2'd3};
            5'd16:   e = {2'd2, 2'd0, 2'd1, 2'd3};
            5'd17:   e = {2'd2, 2'd0, 2'd3, 2'd1};
            5'd18:   e = {2'd3, 2'd0, 2'd2, 2'd1};
            5'd19:   e = {2'd3, 2'd0, 2'd1, 2'd2};
            5'd20:   e = {2'd3, 2'd1, 2'd0, 2'd2};
            5'd21:   e = {2'd3, 2'd1, 2'd2, 2'd0};
            5'd22:   e = {2'd3, 2'd2, 2'd0, 2'd1};
            5'd23:   e = {2'd3, 2'd2, 2'd1, 2'd0};
            5'd24:   e = {2'd3, 2'd2, 2'd1, 2'd0};
            5'd25:   e = {2'd2, 2'd1, 2'd3, 2'd0};
            5'd26:   e = {2'd0, 2'd2, 2'd3, 2'd1};
            5'd27:   e = {2'd1, 2'd0, 2'd2, 2'd3};
            5'd28:   e = {2'd1, 2'd3, 2'd2, 2'd0};
            5'd29:   e = {2'd0, 2'd1, 2'd2, 2'd3};
            5'd30:   e = {2'd3, 2'd0, 2'd1, 2'd2};
            5'd31:   e = {2'd2, 2'd3, 2'd1, 2'd0};
            default: e = {2'd0, 2'd1, 2'd2, 2'd3};
        endcase
        return e;
    endfunction

    // Group i of y lands at unit-element pair (7-2p, 6-2p); 7-2p == {~p,1}.
    function automatic logic [7:0] unscramble(input logic [7:0] y_w, input logic [4:0] idx);
        logic [7:0] e;
        logic [1:0] p;
        logic [7:0] r;
        e = perm_entry(idx);
        r = 8'h00;
        for (int i = 0; i < 4; i++) begin
            p = e[7-2*i -: 2];
            r[{~p, 1'b1}] = y_w[2*i];
            r[{~p, 1'b0}] = y_w[2*i+1];
        end
        return r;
    endfunction

    // Number of active unit elements in a word.
    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    assign inverse_s  = unscramble(bus.y, n_d_r);
    assign ones_s     = popcount(inverse_s);
    assign mismatch_s = chk_valid_r & (x_rec_r != x_dly2_r);

    // FSM state register.
    always_ff @(posedge dem_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_PRIME;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: a single priming edge, then tracking until reset.
    always_comb begin
        state_nxt_s = ST_PRIME;
        case (state_r)
            ST_PRIME: state_nxt_s = ST_TRACK;
            ST_TRACK: state_nxt_s = ST_TRACK;
            default:  state_nxt_s = ST_PRIME;
        endcase
    end

    // FSM output decode.
    always_comb begin
        track_s = 1'b0;
        case (state_r)
            ST_PRIME: track_s = 1'b0;
            ST_TRACK: track_s = 1'b1;
            default:  track_s = 1'b0;
        endcase
    end

    // Rotation index follows the dem block, advancing on each tracking edge.
    always_ff @(posedge dem_clk or negedge reset_n) begin
        if (!reset_n) begin
            n_d_r <= 5'd0;
        end else if (track_s) begin
            n_d_r <= n_d_r + 5'd1;
        end
    end

    // Recovered word, complementary rail copy and popcount, loaded while tracking.
    always_ff @(posedge dem_clk or negedge reset_n) begin
        if (!reset_n) begin
            x_rec_r    <= 8'h00;
            xbar_rec_r <= 8'hFF;
            ones_r     <= 4'd0;
        end else if (track_s) begin
            x_rec_r    <= inverse_s;
            xbar_rec_r <= bus.ybar;
            ones_r     <= ones_s;
        end
    end

    // Reference delay line, so x_dly2_r holds the word now present on x_rec.
    always_ff @(posedge dem_clk or negedge reset_n) begin
        if (!reset_n) begin
            x_dly1_r <= 8'h00;
            x_dly2_r <= 8'h00;
        end else begin
            x_dly1_r <= bus.x_ref;
            x_dly2_r <= x_dly1_r;
        end
    end

    // Comparison is meaningful only once x_rec holds a tracked word.
    always_ff @(posedge dem_clk or negedge reset_n) begin
        if (!reset_n) begin
            chk_valid_r <= 1'b0;
        end else begin
            chk_valid_r <= track_s;
        end
    end

    // Next error state: clear dominates, otherwise count mismatches with saturation.
    always_comb begin
        err_cnt_nxt_s   = err_cnt_r;
        err_pulse_nxt_s = 1'b0;
        if (bus.clr) begin
            err_cnt_nxt_s   = 8'd0;
            err_pulse_nxt_s = 1'b0;
        end else if (mismatch_s) begin
            err_pulse_nxt_s = 1'b1;
            if (err_cnt_r != 8'hFF) begin
                err_cnt_nxt_s = err_cnt_r + 8'd1;
            end else begin
                err_cnt_nxt_s = err_cnt_r;
            end
        end else begin
            err_cnt_nxt_s   = err_cnt_r;
            err_pulse_nxt_s = 1'b0;
        end
    end

    assign locked_nxt_s = (state_nxt_s == ST_TRACK) && (err_cnt_nxt_s == 8'd0);

    // Error strobe, error count and lock flag registers.
    always_ff @(posedge dem_clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_r   <= 8'd0;
            err_pulse_r <= 1'b0;
            locked_r    <= 1'b0;
        end else begin
            err_cnt_r   <= err_cnt_nxt_s;
            err_pulse_r <= err_pulse_nxt_s;
            locked_r    <= locked_nxt_s;
        end
    end

    assign bus.x_rec     = x_rec_r;
    assign bus.xbar_rec  = xbar_rec_r;
    assign bus.ones      = ones_r;
    assign bus.err_pulse = err_pulse_r;
    assign bus.err_cnt   = err_cnt_r;
    assign bus.locked    = locked_r;

endmodule

// File: tb/tb_dem_unscramble.sv
// Bench for dem_unscramble: a behavioural dem scrambler feeds the unscrambler
// from the same clock and reset; expected words are queued when driven and
// checked when they emerge two cycles later.
module tb_dem_unscramble;

    logic       dem_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] x_drv   = 8'h00;
    logic [7:0] y_flip  = 8'h00;
    logic       y_ovr_en = 1'b0;
    logic [7:0] y_ovr   = 8'h00;
    logic       clr_drv = 1'b0;

    int n_pass   = 0;
    int n_total  = 0;
    int edge_cnt = 0;

    typedef struct {
        logic [7:0] x;
        logic [7:0] yb;
    } exp_t;
    exp_t exp_q[$];

    // Permutation digits p0 p1 p2 p3 as hex nibbles.
    localparam logic [15:0] TBL [0:31] = '{
        16'h0123, 16'h0132, 16'h0213, 16'h0231, 16'h0312, 16'h0321, 16'h1023, 16'h1032,
        16'h1230, 16'h1203, 16'h1320, 16'h1302, 16'h2301, 16'h2310, 16'h2130, 16'h2103,
        16'h2013, 16'h2031, 16'h3021, 16'h3012, 16'h3102, 16'h3120, 16'h3201, 16'h3210,
        16'h3210, 16'h2130, 16'h0231, 16'h1023, 16'h1320, 16'h0123, 16'h3012, 16'h2310
    };

    // Forward scramble done by the dem block.
    function automatic logic [7:0] scr(input logic [7:0] x, input logic [4:0] n);
        logic [15:0] e;
        int p;
        logic [7:0] r;
        e = TBL[n];
        r = 8'h00;
        for (int i = 0; i < 4; i++) begin
            p = int'(e[15-4*i -: 4]);
            r[2*i]   = x[7-2*p];
            r[2*i+1] = x[6-2*p];
        end
        return r;
    endfunction

    always #5 dem_clk = ~dem_clk;

    // Behavioural dem block: registers the scrambled word and advances its index.
    logic [4:0] dem_n_r;
    logic [7:0] dem_y_r;
    logic [7:0] dem_ybar_r;
    always_ff @(posedge dem_clk or negedge reset_n) begin
        if (!reset_n) begin
            dem_n_r    <= 5'd0;
            dem_y_r    <= 8'h00;
            dem_ybar_r <= 8'hFF;
        end else begin
            dem_y_r    <= scr(x_drv, dem_n_r);
            dem_ybar_r <= ~scr(x_drv, dem_n_r);
            dem_n_r    <= dem_n_r + 5'd1;
        end
    end

    dem_unscramble_if u_if ();

    assign u_if.y     = y_ovr_en ? y_ovr : (dem_y_r ^ y_flip);
    assign u_if.ybar  = dem_ybar_r;
    assign u_if.x_ref = x_drv;
    assign u_if.clr   = clr_drv;

    dem_unscramble dut (
        .dem_clk (dem_clk),
        .reset_n (reset_n),
        .bus     (u_if.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x_rec"},     {24'd0, u_if.x_rec},     32'h00);
        chk({tag, "_xbar_rec"},  {24'd0, u_if.xbar_rec},  32'hFF);
        chk({tag, "_ones"},      {28'd0, u_if.ones},      32'd0);
        chk({tag, "_err_pulse"}, {31'd0, u_if.err_pulse}, 32'd0);
        chk({tag, "_err_cnt"},   {24'd0, u_if.err_cnt},   32'd0);
        chk({tag, "_locked"},    {31'd0, u_if.locked},    32'd0);
    endtask

    // Reset asserted asynchronously between edges, released on a falling edge.
    task automatic do_reset(input string tag);
        #2;
        reset_n  = 1'b0;
        x_drv    = 8'h00;
        y_flip   = 8'h00;
        y_ovr_en = 1'b0;
        clr_drv  = 1'b0;
        #1;
        chk_reset_vals(tag);
        @(negedge dem_clk);
        @(negedge dem_clk);
        reset_n  = 1'b1;
        edge_cnt = 0;
        exp_q.delete();
    endtask

    // One dem cycle: drive x_ref, clock, then check the word that emerges.
    task automatic step(input logic [7:0] xv, input logic [7:0] flip, input bit chk_data);
        exp_t e;
        x_drv  = xv;
        y_flip = flip;
        e.x    = xv;
        e.yb   = ~scr(xv, dem_n_r);
        exp_q.push_back(e);
        @(posedge dem_clk);
        edge_cnt++;
        @(negedge dem_clk);
        y_flip = 8'h00;
        if (edge_cnt == 1) begin
            chk("prime_x_rec",    {24'd0, u_if.x_rec},    32'h00);
            chk("prime_xbar_rec", {24'd0, u_if.xbar_rec}, 32'hFF);
            chk("prime_locked",   {31'd0, u_if.locked},   32'd1);
        end else begin
            e = exp_q.pop_front();
            if (chk_data) begin
                chk("x_rec",    {24'd0, u_if.x_rec},    {24'd0, e.x});
                chk("ones",     {28'd0, u_if.ones},     32'($countones(e.x)));
                chk("xbar_rec", {24'd0, u_if.xbar_rec}, {24'd0, e.yb});
            end
        end
    endtask

    initial begin
        logic [7:0] xv;

        // Reset state and constant all-ones input.
        @(negedge dem_clk);
        do_reset("rst0");
        for (int i = 0; i < 20; i++) begin
            step(8'hFF, 8'h00, 1'b1);
            chk("ff_pulse", {31'd0, u_if.err_pulse}, 32'd0);
        end
        chk("ff_err_cnt", {24'd0, u_if.err_cnt}, 32'd0);
        chk("ff_locked",  {31'd0, u_if.locked},  32'd1);

        // Walking one across two full index wraps.
        for (int i = 0; i < 64; i++) begin
            xv = 8'h01 << i[2:0];
            step(xv, 8'h00, 1'b1);
            chk("walk_pulse", {31'd0, u_if.err_pulse}, 32'd0);
        end
        chk("walk_err_cnt", {24'd0, u_if.err_cnt}, 32'd0);
        chk("walk_locked",  {31'd0, u_if.locked},  32'd1);

        // Single corrupted y bit on edge 10.
        do_reset("rst1");
        for (int i = 1; i <= 9; i++) begin
            step(8'($urandom_range(255, 0)), 8'h00, 1'b1);
        end
        step(8'h3C, 8'h10, 1'b0);
        chk("c10_pulse_pre", {31'd0, u_if.err_pulse}, 32'd0);
        step(8'($urandom_range(255, 0)), 8'h00, 1'b1);
        chk("c10_pulse_hi", {31'd0, u_if.err_pulse}, 32'd1);
        chk("c10_err_cnt",  {24'd0, u_if.err_cnt},   32'd1);
        chk("c10_locked",   {31'd0, u_if.locked},    32'd0);
        step(8'($urandom_range(255, 0)), 8'h00, 1'b1);
        chk("c10_pulse_lo", {31'd0, u_if.err_pulse}, 32'd0);
        chk("c10_err_hold", {24'd0, u_if.err_cnt},   32'd1);
        chk("c10_locked2",  {31'd0, u_if.locked},    32'd0);
        for (int i = 0; i < 5; i++) begin
            step(8'($urandom_range(255, 0)), 8'h00, 1'b1);
        end
        chk("c10_locked3", {31'd0, u_if.locked}, 32'd0);
        clr_drv = 1'b1;
        step(8'h77, 8'h00, 1'b1);
        clr_drv = 1'b0;
        chk("clr_err_cnt", {24'd0, u_if.err_cnt}, 32'd0);
        chk("clr_locked",  {31'd0, u_if.locked},  32'd1);

        // 300 corrupted cycles saturate the counter; clear wins over a mismatch.
        for (int i = 0; i < 300; i++) begin
            step(8'($urandom_range(255, 0)), 8'h01, 1'b0);
        end
        chk("sat_err_cnt", {24'd0, u_if.err_cnt},   32'd255);
        chk("sat_pulse",   {31'd0, u_if.err_pulse}, 32'd1);
        chk("sat_locked",  {31'd0, u_if.locked},    32'd0);
        clr_drv = 1'b1;
        step(8'hA5, 8'h00, 1'b1);
        clr_drv = 1'b0;
        chk("clrwin_err_cnt", {24'd0, u_if.err_cnt},   32'd0);
        chk("clrwin_pulse",   {31'd0, u_if.err_pulse}, 32'd0);
        chk("clrwin_locked",  {31'd0, u_if.locked},    32'd1);
        step(8'h5A, 8'h00, 1'b1);
        chk("post_clr_pulse", {31'd0, u_if.err_pulse}, 32'd0);
        chk("post_clr_cnt",   {24'd0, u_if.err_cnt},   32'd0);

        // Direct y at index 4 (edges 6 and 38 after reset).
        do_reset("rst2");
        for (int i = 1; i <= 5; i++) begin
            step(8'h5A, 8'h00, 1'b1);
        end
        y_ovr_en = 1'b1;
        y_ovr    = 8'h01;
        step(8'h5A, 8'h00, 1'b0);
        y_ovr_en = 1'b0;
        chk("nd4_y01_x_rec", {24'd0, u_if.x_rec}, 32'h80);
        chk("nd4_y01_ones",  {28'd0, u_if.ones},  32'd1);
        for (int i = 7; i <= 37; i++) begin
            step(8'h5A, 8'h00, 1'b1);
        end
        y_ovr_en = 1'b1;
        y_ovr    = 8'h04;
        step(8'h5A, 8'h00, 1'b0);
        y_ovr_en = 1'b0;
        chk("nd4_y04_x_rec", {24'd0, u_if.x_rec},   32'h02);
        chk("nd4_y04_ones",  {28'd0, u_if.ones},    32'd1);
        chk("nd4_err_cnt",   {24'd0, u_if.err_cnt}, 32'd1);
        chk("nd4_locked",    {31'd0, u_if.locked},  32'd0);

        // Run on to index 17 (edge 50), then reset mid-stream and re-align.
        for (int i = 39; i <= 50; i++) begin
            step(8'($urandom_range(255, 0)), 8'h00, 1'b1);
        end
        chk("pre_rst_err_cnt", {24'd0, u_if.err_cnt}, 32'd2);
        do_reset("rst_mid");
        for (int i = 0; i < 40; i++) begin
            step(8'($urandom_range(255, 0)), 8'h00, 1'b1);
            chk("realign_pulse", {31'd0, u_if.err_pulse}, 32'd0);
        end
        chk("realign_err_cnt", {24'd0, u_if.err_cnt}, 32'd0);
        chk("realign_locked",  {31'd0, u_if.locked},  32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
